mem_bus_arbiter: RTL

- Shares the single memory port between two requesters: the instruction-fetch side (IF) and the data side (mem_ctrl, DM).
- Drives the memory address, strobe, read/write and write-data signals, and returns read data and a one-cycle ack to the granted requester.
- DM has fixed priority over IF. A starvation counter forces an IF grant after STARVE_MAX consecutive DM grants while IF is waiting.

---
 rtl/mem_bus_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory port arbiter. The data side (DM) has priority over
// instruction fetch (IF). A starvation counter can force an IF grant. Each
// access uses one strobe cycle (ACCESS) followed by one response cycle (RESP).
// The next grant can be made from RESP, so a new access can start every 2 cycles.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rd_data,
    output logic              if_stall,

    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic              dm_rw,
    input  logic [DATA_W-1:0] dm_wr_data,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rd_data,
    output logic              dm_stall,

    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // STARVE_MAX is limited to 1..15, so 4 bits are enough.
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       owner;
    logic [3:0] starve_cnt;

    logic in_resp;
    logic arb_en;
    logic if_wait;
    logic dm_wait;
    logic force_if;
    logic grant_if;
    logic grant_dm;
    logic grant_any;

    // The acks decode from the registered state and owner, so each ack is a clean one-cycle pulse.
    assign in_resp  = (state == S_RESP);
    assign if_ack   = in_resp && (owner == OWN_IF);
    assign dm_ack   = in_resp && (owner == OWN_DM);

    // Read data passes straight through to the owner. The other requester sees zero.
    assign if_rd_data = if_ack ? bus_rd_data : '0;
    assign dm_rd_data = dm_ack ? bus_rd_data : '0;

    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

    // A requester's req is still high in its own ack cycle. Masking it here
    // stops the arbiter from serving the finished request a second time.
    assign arb_en    = (state == S_IDLE) || in_resp;
    assign if_wait   = if_req & ~if_ack;
    assign dm_wait   = dm_req & ~dm_ack;
    assign force_if  = if_wait && (starve_cnt == STARVE_LIM);
    assign grant_if  = arb_en && if_wait && (force_if || !dm_wait);
    assign grant_dm  = arb_en && dm_wait && !force_if;
    assign grant_any = grant_if || grant_dm;

    // Next-state decode: ACCESS always moves to RESP. IDLE and RESP start a new access on any grant.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:   state_nxt = grant_any ? S_ACCESS : S_IDLE;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = grant_any ? S_ACCESS : S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State, owner and bus drive. The bus fields load only on a grant and hold through RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            owner       <= OWN_IF;
            bus_as_     <= 1'b1;
            bus_rw      <= 1'b0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
        end else begin
            state   <= state_nxt;
            bus_as_ <= ~grant_any;
            if (grant_dm) begin
                owner       <= OWN_DM;
                bus_addr    <= dm_addr;
                bus_rw      <= dm_rw;
                bus_wr_data <= dm_wr_data;
            end else if (grant_if) begin
                owner       <= OWN_IF;
                bus_addr    <= if_addr;
                bus_rw      <= 1'b0;
                bus_wr_data <= '0;
            end
        end
    end

    // Count DM grants made while IF waits. Clear on an IF grant or whenever IF is not requesting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!if_req || grant_if) begin
            starve_cnt <= '0;
        end else if (grant_dm && if_wait && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule
